// File: rtl/pc_stack_unit.sv
// Program-counter unit with increment, relative branch, absolute jump and a
// hardware return-address stack for call/return.
module pc_stack_unit #(
  parameter int              AW        = 18,
  parameter int              OFFW      = 10,
  parameter int              STEP      = 1,
  parameter int              RAS_DEPTH = 8,
  parameter logic [AW-1:0]   RESET_VEC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         stall,
  input  logic [2:0]                   op,
  input  logic [AW-1:0]                target,
  input  logic [OFFW-1:0]              offset,
  input  logic                         clr_err,
  output logic [AW-1:0]                pc_out,
  output logic [AW-1:0]                ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_full,
  output logic                         ras_empty,
  output logic                         err_ovf,
  output logic                         err_unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] OP_INC     = 3'd1;
  localparam logic [2:0] OP_BRANCH  = 3'd2;
  localparam logic [2:0] OP_JUMP    = 3'd3;
  localparam logic [2:0] OP_CALL    = 3'd4;
  localparam logic [2:0] OP_RET     = 3'd5;
  localparam logic [2:0] OP_RAS_CLR = 3'd6;

  logic [AW-1:0] stack [RAS_DEPTH];
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_br;
  logic [AW-1:0] off_ext;
  logic [PW-1:0] push_idx;
  logic [PW-1:0] below_top_idx;
  logic          exec;

  assign exec          = en & ~stall;
  assign off_ext       = {{(AW-OFFW){offset[OFFW-1]}}, offset};
  assign pc_inc        = pc_out + AW'(STEP);
  assign pc_br         = pc_out + off_ext;
  assign push_idx      = ras_count[PW-1:0];
  assign below_top_idx = PW'(ras_count - CW'(2));
  assign ras_full      = (ras_count == CW'(RAS_DEPTH));
  assign ras_empty     = (ras_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out    <= RESET_VEC;
      ras_top   <= '0;
      ras_count <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else begin
      // Clear first so a coinciding error event below overrides it.
      if (clr_err) begin
        err_ovf <= 1'b0;
        err_unf <= 1'b0;
      end
      if (exec) begin
        case (op)
          OP_INC:    pc_out <= pc_inc;
          OP_BRANCH: pc_out <= pc_br;
          OP_JUMP:   pc_out <= target;
          OP_CALL: begin
            pc_out <= target;
            if (!ras_full) begin
              stack[push_idx] <= pc_inc;
              ras_top         <= pc_inc;
              ras_count       <= ras_count + CW'(1);
            end else begin
              err_ovf <= 1'b1;
            end
          end
          OP_RET: begin
            if (!ras_empty) begin
              pc_out    <= ras_top;
              ras_count <= ras_count - CW'(1);
              ras_top   <= (ras_count >= CW'(2)) ? stack[below_top_idx] : '0;
            end else begin
              pc_out  <= pc_inc;
              err_unf <= 1'b1;
            end
          end
          OP_RAS_CLR: begin
            pc_out    <= pc_inc;
            ras_count <= '0;
            ras_top   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_pc_stack_unit;
  localparam int AW = 18;
  localparam int OFFW = 10;
  localparam int DEPTH = 8;

  localparam logic [2:0] NOP = 3'd0, INC = 3'd1, BRANCH = 3'd2, JUMP = 3'd3,
                         CALL = 3'd4, RET = 3'd5, RCLR = 3'd6, RSV = 3'd7;

  logic            clk = 1'b0;
  logic            rst, en, stall, clr_err;
  logic [2:0]      op;
  logic [AW-1:0]   target;
  logic [OFFW-1:0] offset;
  logic [AW-1:0]   pc_out, ras_top;
  logic [3:0]      ras_count;
  logic            ras_full, ras_empty, err_ovf, err_unf;

  int checks = 0;
  int failures = 0;

  // reference model
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_q[$];
  logic          m_ovf, m_unf;

  pc_stack_unit dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .op(op), .target(target),
    .offset(offset), .clr_err(clr_err), .pc_out(pc_out), .ras_top(ras_top),
    .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  function automatic void model_step();
    if (rst) begin
      m_pc = '0; m_q.delete(); m_ovf = 0; m_unf = 0;
      return;
    end
    if (clr_err) begin m_ovf = 0; m_unf = 0; end
    if (!(en && !stall)) return;
    case (op)
      INC:    m_pc = m_pc + 18'd1;
      BRANCH: m_pc = AW'(int'(m_pc) + int'($signed(offset)));
      JUMP:   m_pc = target;
      CALL: begin
        if (m_q.size() < DEPTH) m_q.push_back(m_pc + 18'd1);
        else m_ovf = 1;
        m_pc = target;
      end
      RET: begin
        if (m_q.size() > 0) m_pc = m_q.pop_back();
        else begin m_pc = m_pc + 18'd1; m_unf = 1; end
      end
      RCLR: begin m_q.delete(); m_pc = m_pc + 18'd1; end
      default: ;
    endcase
  endfunction

  // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic cyc(input logic r, input logic e, input logic s, input logic [2:0] o,
                     input logic [AW-1:0] t, input logic [OFFW-1:0] of, input logic c);
    rst = r; en = e; stall = s; op = o; target = t; offset = of; clr_err = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, NOP, 0, 0, 0);
    cyc(1, 0, 0, NOP, 0, 0, 0);
    checks++; if (pc_out !== 18'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    checks++; if (ras_count !== 4'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_top !== 18'h0) begin
      failures++; $display("FAIL reset_ras count=%0d empty=%b full=%b top=%h exp 0/1/0/0", ras_count, ras_empty, ras_full, ras_top); end
    checks++; if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      failures++; $display("FAIL reset_flags ovf=%b unf=%b exp 0/0", err_ovf, err_unf); end
  endtask

  task automatic test_inc();
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 1, 0, INC, 0, 0, 0);
      checks++; if (pc_out !== AW'(i)) begin failures++; $display("FAIL inc_pc step=%0d got=%h exp=%h", i, pc_out, AW'(i)); end
    end
    checks++; if (ras_empty !== 1'b1 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      failures++; $display("FAIL inc_state empty=%b ovf=%b unf=%b exp 1/0/0", ras_empty, err_ovf, err_unf); end
  endtask

  task automatic test_branch_wrap();
    cyc(0, 1, 0, JUMP, 18'h00005, 0, 0);
    checks++; if (pc_out !== 18'h00005) begin failures++; $display("FAIL jump_pc got=%h exp=00005", pc_out); end
    cyc(0, 1, 0, BRANCH, 0, 10'h3FA, 0);
    checks++; if (pc_out !== 18'h3FFFF) begin failures++; $display("FAIL branch_neg got=%h exp=3ffff", pc_out); end
    cyc(0, 1, 0, INC, 0, 0, 0);
    checks++; if (pc_out !== 18'h00000) begin failures++; $display("FAIL inc_wrap got=%h exp=00000", pc_out); end
    cyc(0, 1, 0, BRANCH, 0, 10'h1FF, 0);
    checks++; if (pc_out !== 18'h001FF) begin failures++; $display("FAIL branch_pos got=%h exp=001ff", pc_out); end
  endtask

  task automatic test_call_ret();
    cyc(0, 1, 0, JUMP, 18'h100, 0, 0);
    cyc(0, 1, 0, CALL, 18'h200, 0, 0);
    checks++; if (pc_out !== 18'h200 || ras_top !== 18'h101 || ras_count !== 4'd1) begin
      failures++; $display("FAIL call1 pc=%h top=%h count=%0d exp 200/101/1", pc_out, ras_top, ras_count); end
    cyc(0, 1, 0, CALL, 18'h300, 0, 0);
    checks++; if (pc_out !== 18'h300 || ras_top !== 18'h201 || ras_count !== 4'd2) begin
      failures++; $display("FAIL call2 pc=%h top=%h count=%0d exp 300/201/2", pc_out, ras_top, ras_count); end
    cyc(0, 1, 0, RET, 0, 0, 0);
    checks++; if (pc_out !== 18'h201 || ras_top !== 18'h101 || ras_count !== 4'd1) begin
      failures++; $display("FAIL ret1 pc=%h top=%h count=%0d exp 201/101/1", pc_out, ras_top, ras_count); end
    cyc(0, 1, 0, RET, 0, 0, 0);
    checks++; if (pc_out !== 18'h101 || ras_empty !== 1'b1 || ras_top !== 18'h0) begin
      failures++; $display("FAIL ret2 pc=%h empty=%b top=%h exp 101/1/0", pc_out, ras_empty, ras_top); end
  endtask

  task automatic test_overflow();
    cyc(0, 1, 0, JUMP, 18'h0, 0, 0);
    for (int k = 1; k <= DEPTH; k++) cyc(0, 1, 0, CALL, AW'(k * 16), 0, 0);
    checks++; if (ras_full !== 1'b1 || ras_count !== 4'd8 || ras_top !== 18'h71 || pc_out !== 18'h80) begin
      failures++; $display("FAIL fill full=%b count=%0d top=%h pc=%h exp 1/8/71/80", ras_full, ras_count, ras_top, pc_out); end
    cyc(0, 1, 0, CALL, 18'h3AA, 0, 0);
    checks++; if (pc_out !== 18'h3AA || ras_count !== 4'd8 || ras_top !== 18'h71 || err_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_call pc=%h count=%0d top=%h ovf=%b exp 3aa/8/71/1", pc_out, ras_count, ras_top, err_ovf); end
    cyc(0, 1, 0, NOP, 0, 0, 1);
    checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", err_ovf); end
    cyc(0, 1, 0, CALL, 18'h3AB, 0, 1);
    checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", err_ovf); end
    cyc(0, 1, 0, RET, 0, 0, 0);
    checks++; if (pc_out !== 18'h71 || ras_top !== 18'h61 || ras_count !== 4'd7) begin
      failures++; $display("FAIL ret_from_full pc=%h top=%h count=%0d exp 71/61/7", pc_out, ras_top, ras_count); end
    cyc(0, 1, 0, RCLR, 0, 0, 0);
    checks++; if (ras_count !== 4'd0 || ras_top !== 18'h0 || pc_out !== 18'h72 || err_ovf !== 1'b1) begin
      failures++; $display("FAIL ras_clr count=%0d top=%h pc=%h ovf=%b exp 0/0/72/1", ras_count, ras_top, pc_out, err_ovf); end
    cyc(0, 1, 0, NOP, 0, 0, 1);
  endtask

  task automatic test_underflow_stall();
    cyc(0, 1, 0, JUMP, 18'h40, 0, 0);
    cyc(0, 1, 0, RET, 0, 0, 0);
    checks++; if (pc_out !== 18'h41 || err_unf !== 1'b1 || ras_count !== 4'd0) begin
      failures++; $display("FAIL unf_ret pc=%h unf=%b count=%0d exp 41/1/0", pc_out, err_unf, ras_count); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, JUMP, 18'h77, 0, 0);
      checks++; if (pc_out !== 18'h41) begin failures++; $display("FAIL stall_hold cyc=%0d got=%h exp=41", i, pc_out); end
    end
    cyc(0, 1, 1, CALL, 18'h99, 0, 1);
    checks++; if (err_unf !== 1'b0 || ras_count !== 4'd0 || pc_out !== 18'h41) begin
      failures++; $display("FAIL stall_clr unf=%b count=%0d pc=%h exp 0/0/41", err_unf, ras_count, pc_out); end
    cyc(0, 1, 0, JUMP, 18'h77, 0, 0);
    checks++; if (pc_out !== 18'h77) begin failures++; $display("FAIL stall_release got=%h exp=77", pc_out); end
    cyc(0, 0, 0, JUMP, 18'h55, 0, 0);
    checks++; if (pc_out !== 18'h77) begin failures++; $display("FAIL en_low got=%h exp=77", pc_out); end
    cyc(0, 1, 0, RSV, 18'h55, 0, 0);
    checks++; if (pc_out !== 18'h77) begin failures++; $display("FAIL op7_nop got=%h exp=77", pc_out); end
  endtask

  task automatic test_reset_mid();
    cyc(0, 1, 0, CALL, 18'h500, 0, 0);
    cyc(0, 1, 0, CALL, 18'h600, 0, 0);
    cyc(0, 1, 0, CALL, 18'h1234, 0, 0);
    checks++; if (ras_count !== 4'd3 || pc_out !== 18'h1234) begin
      failures++; $display("FAIL pre_rst count=%0d pc=%h exp 3/1234", ras_count, pc_out); end
    cyc(1, 1, 0, CALL, 18'h2000, 0, 0);
    checks++; if (pc_out !== 18'h0 || ras_count !== 4'd0 || ras_top !== 18'h0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      failures++; $display("FAIL rst_mid pc=%h count=%0d top=%h ovf=%b unf=%b exp 0/0/0/0/0", pc_out, ras_count, ras_top, err_ovf, err_unf); end
    cyc(0, 1, 0, RET, 0, 0, 0);
    checks++; if (pc_out !== 18'h1 || err_unf !== 1'b1) begin
      failures++; $display("FAIL rst_no_push pc=%h unf=%b exp 1/1", pc_out, err_unf); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] base;
    cyc(0, 1, 0, JUMP, 18'h2AAA0, 0, 1);
    base = 18'h2AAA0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, CALL, 18'h3F000 + AW'(i), 0, 0);
      checks++; if (pc_out !== 18'h3F000 + AW'(i) || ras_top !== base + 18'd1) begin
        failures++; $display("FAIL b2b_call i=%0d pc=%h top=%h exp %h/%h", i, pc_out, ras_top, 18'h3F000 + AW'(i), base + 18'd1); end
      cyc(0, 1, 0, RET, 0, 0, 0);
      base = base + 18'd1;
      checks++; if (pc_out !== base || ras_count !== 4'd0) begin
        failures++; $display("FAIL b2b_ret i=%0d pc=%h count=%0d exp %h/0", i, pc_out, ras_count, base); end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] e_top;
    logic [2:0]    o;
    for (int n = 0; n < 600; n++) begin
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 3) o = CALL;
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), o,
          AW'($urandom), OFFW'($urandom), ($urandom_range(0, 19) == 0));
      e_top = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
      checks++; if (pc_out !== m_pc) begin failures++; $display("FAIL rand_pc n=%0d got=%h exp=%h", n, pc_out, m_pc); end
      checks++; if (ras_top !== e_top) begin failures++; $display("FAIL rand_top n=%0d got=%h exp=%h", n, ras_top, e_top); end
      checks++; if (ras_count !== 4'(m_q.size())) begin failures++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, ras_count, m_q.size()); end
      checks++; if (ras_full !== (m_q.size() == DEPTH) || ras_empty !== (m_q.size() == 0)) begin
        failures++; $display("FAIL rand_fe n=%0d full=%b empty=%b size=%0d", n, ras_full, ras_empty, m_q.size()); end
      checks++; if (err_ovf !== m_ovf || err_unf !== m_unf) begin
        failures++; $display("FAIL rand_flags n=%0d ovf=%b unf=%b exp %b/%b", n, err_ovf, err_unf, m_ovf, m_unf); end
    end
  endtask

  initial begin
    rst = 1; en = 0; stall = 0; op = NOP; target = '0; offset = '0; clr_err = 0;
    m_pc = '0; m_ovf = 0; m_unf = 0;
    test_reset();
    test_inc();
    test_branch_wrap();
    test_call_ret();
    test_overflow();
    test_underflow_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
